// File: rtl/instr_pkg.sv
// Shared instruction-set constants for the encoder and the ID-stage control decoder:
// opcodes, the request type codes, the NOP word and the encoder FSM states.
package instr_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // All-zero opcode: the ID-stage control treats this word as a no-op.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Request type codes as presented on type_i.
    typedef enum logic [2:0] {
        TYPE_R      = 3'd0,
        TYPE_I      = 3'd1,
        TYPE_LOAD   = 3'd2,
        TYPE_STORE  = 3'd3,
        TYPE_BRANCH = 3'd4,
        TYPE_NOP    = 3'd5,
        TYPE_ILL6   = 3'd6,
        TYPE_ILL7   = 3'd7
    } instr_type_e;

    // Encoder control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_e;

    // One pending instruction-memory write.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } mem_wr_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: request type, funct, register indices and immediate
// in, 32-bit instruction word and illegal flag out.
// Build option ENC_IMM_CHECK_EN: a Branch with an odd byte offset (imm[0]=1) is
// flagged illegal; without it imm[0] is simply dropped for Branch.
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [3:0]  i_funct,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    instr_type_e w_type;
    logic [2:0]  w_f3;

    assign w_type = instr_type_e'(i_type);
    assign w_f3   = i_funct[2:0];

    // Select the field layout for the request type; unknown types flag illegal.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_word    = NOP_WORD;
        o_illegal = 1'b0;
        case (w_type)
            TYPE_R:
                o_word = {1'b0, i_funct[3], 5'b0, i_rs2, i_rs1, w_f3, i_rd, OP_R};
            TYPE_I:
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OP_I};
            TYPE_LOAD:
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OP_LOAD};
            TYPE_STORE:
                o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], OP_STORE};
            TYPE_BRANCH: begin
`ifdef ENC_IMM_CHECK_EN
                if (i_imm[0]) begin
                    o_illegal = 1'b1;
                end else begin
                    o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                              i_imm[4:1], i_imm[11], OP_BRANCH};
                end
`else
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                          i_imm[4:1], i_imm[11], OP_BRANCH};
`endif
            end
            TYPE_NOP:
                o_word = NOP_WORD;
            default:
                o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one request at a time, packs it into a 32-bit word
// and writes it to consecutive instruction-memory words starting at BASE_ADDR,
// stopping when DEPTH words are written until clear_i restarts the pointer.
// Build option ENC_IMM_CHECK_EN (handled in instr_pack) rejects odd Branch offsets.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               type_i,
    input  logic [3:0]               funct_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [12:0]              imm_i,
    input  logic                     clear_i,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     err_o
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    enc_state_e    r_state;
    enc_state_e    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_inc;
    mem_wr_t       r_wr;
    logic          r_err;
    logic [31:0]   w_word;
    logic [31:0]   w_addr;
    logic          w_illegal;
    logic          w_accept;

    instr_pack u_pack (
        .i_type    (type_i),
        .i_funct   (funct_i),
        .i_rd      (rd_i),
        .i_rs1     (rs1_i),
        .i_rs2     (rs2_i),
        .i_imm     (imm_i),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_count_inc = r_count + CW'(1);
    // Pre-increment word address; count is below DEPTH whenever a request is accepted.
    assign w_addr      = BASE_ADDR + (32'(r_count) << 2);

    // State register; reset aborts any write in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and write-enable decode; clear beats a new request.
    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        mem_we_o    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready_o  = 1'b1;
                w_accept = valid_i && !clear_i;
                if (w_accept && !w_illegal) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we_o = 1'b1;
                if (clear_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_count_inc == DEPTH_C) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (clear_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word counter: advances as WRITE completes, restarts on clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (r_state == ST_WRITE) begin
            r_count <= clear_i ? '0 : w_count_inc;
        end else if (clear_i) begin
            r_count <= '0;
        end
    end

    // Capture address and encoded word at acceptance; both hold outside WRITE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: the write-port registers are reset to known values because they
            // are visible outputs; this is a register pair, not a storage array.
            r_wr <= '{addr: BASE_ADDR, data: 32'h0};
        end else if (w_accept && !w_illegal) begin
            r_wr <= '{addr: w_addr, data: w_word};
        end
    end

    // One-cycle error pulse for an accepted illegal request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;
        end
    end

    assign count_o    = r_count;
    assign full_o     = (r_count == DEPTH_C);
    assign err_o      = r_err;
    assign mem_addr_o = r_wr.addr;
    assign mem_data_o = r_wr.data;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4, non-zero base): expected writes are
// queued when a request is driven and matched against each observed memory write.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [2:0]  type_i = '0;
    logic [3:0]  funct_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [12:0] imm_i = '0;
    logic        ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        err_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   model_count = 0;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .type_i     (type_i),
        .funct_i    (funct_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .clear_i    (clear_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge once ready; queue the write it should cause.
    task automatic send(input logic [2:0] t, input logic [3:0] f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                        input logic exp_wr, input logic [31:0] exp_data);
        int n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
        type_i  = t;
        funct_i = f;
        rd_i    = rd;
        rs1_i   = rs1;
        rs2_i   = rs2;
        imm_i   = imm;
        valid_i = 1'b1;
        if (exp_wr) begin
            sb_q.push_back('{addr: BASE + 32'(model_count) * 32'd4, data: exp_data});
            model_count++;
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    // Every observed write must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_data", mem_data_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values while rst_i is low.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, BASE);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // R type, funct7 bit 5 clear and set.
        send(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
        check("r_we_latency", 32'(mem_we_o), 32'd1);
        send(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h402081B3);
        @(posedge clk_i);
        #1;
        check("count_two", 32'(count_o), 32'd2);

        // clear together with valid in IDLE: clear wins, nothing written.
        @(negedge clk_i);
        type_i  = 3'd1;
        valid_i = 1'b1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        model_count = 0;
        check("clear_count", 32'(count_o), 32'd0);
        check("clear_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        check("clear_no_write", 32'(mem_we_o), 32'd0);

        // I-arith and Store.
        send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 32'h00500093);
        send(3'd3, 4'b0010, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1, 32'h0020A423);

        // Illegal type 7: one-cycle error pulse, count unchanged.
        send(3'd7, 4'b0000, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 32'h0);
        check("ill_err_hi", 32'(err_o), 32'd1);
        check("ill_count", 32'(count_o), 32'd2);
        check("ill_we", 32'(mem_we_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("ill_err_lo", 32'(err_o), 32'd0);
        check("ill_ready", 32'(ready_o), 32'd1);

        // Branch with offset -8, then odd offset 5.
        send(3'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 32'hFE208CE3);
`ifdef ENC_IMM_CHECK_EN
        send(3'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b0, 32'h0);
        check("br_odd_err", 32'(err_o), 32'd1);
        check("br_odd_count", 32'(count_o), 32'd3);
        // Load fills the last word.
        send(3'd2, 4'b0010, 5'd5, 5'd2, 5'd0, 13'h010, 1'b1, 32'h01012283);
`else
        send(3'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b1, 32'h00208263);
`endif
        @(posedge clk_i);
        #1;
        check("full_flag", 32'(full_o), 32'd1);
        check("full_ready", 32'(ready_o), 32'd0);
        check("full_count", 32'(count_o), 32'd4);
`ifdef ENC_IMM_CHECK_EN
        check("full_data_hold", mem_data_o, 32'h01012283);
`else
        check("full_data_hold", mem_data_o, 32'h00208263);
`endif

        // A fifth request while full is ignored.
        @(negedge clk_i);
        type_i  = 3'd0;
        valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("fifth_count", 32'(count_o), 32'd4);
        check("fifth_addr_hold", mem_addr_o, BASE + 32'd12);

        // clear from FULL restarts at BASE.
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        model_count = 0;
        check("unfull_count", 32'(count_o), 32'd0);
        check("unfull_flag", 32'(full_o), 32'd0);
        check("unfull_ready", 32'(ready_o), 32'd1);
        send(3'd5, 4'b0000, 5'd7, 5'd7, 5'd7, 13'h7FF, 1'b1, 32'h0000_0000);

        // clear during WRITE: write completes, then count returns to 0.
        send(3'd2, 4'b0010, 5'd5, 5'd2, 5'd0, 13'h010, 1'b1, 32'h01012283);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        model_count = 0;
        check("wclear_count", 32'(count_o), 32'd0);
        check("wclear_ready", 32'(ready_o), 32'd1);

        // Reset during WRITE aborts the write immediately.
        send(3'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
        send(3'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h402081B3);
        #1;
        rst_i = 1'b0;
        #1;
        void'(sb_q.pop_back());
        model_count = 0;
        check("arst_we", 32'(mem_we_o), 32'd0);
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_addr", mem_addr_o, BASE);
        check("arst_data", mem_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        send(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 32'h00500093);
        repeat (2) @(posedge clk_i);
        #1;
        check("post_rst_count", 32'(count_o), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
